// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter sharing one single-port data memory
// between NUM_CORES cores, plus the processor-level completion flag.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   core_req/we/addr/wdata    per-core request (flattened addr/wdata buses)
//   core_ack                  one-hot 1-cycle completion pulse
//   core_rdata                read data, valid with the ack of a read
//   core_done                 per-core halted flags
//   mem_en/we/addr/wdata      registered memory port command
//   mem_rdata                 memory read data (1-cycle latency)
//   proc_state                sticky: all cores done and arbiter idle
module core_mem_arbiter #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_CORES-1:0]            core_req,
  input  logic [NUM_CORES-1:0]            core_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*WIDTH-1:0]      core_wdata,
  output logic [NUM_CORES-1:0]            core_ack,
  output logic [WIDTH-1:0]                core_rdata,
  input  logic [NUM_CORES-1:0]            core_done,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [WIDTH-1:0]                mem_wdata,
  input  logic [WIDTH-1:0]                mem_rdata,
  output logic                            proc_state
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic [NUM_CORES-1:0]   core_ack_q, core_ack_d;
  logic [WIDTH-1:0]       core_rdata_q, core_rdata_d;
  logic                   proc_state_q, proc_state_d;

  logic [NUM_CORES-1:0]   elig;
  logic                   found;
  logic [IDX_W-1:0]       win_idx;
  int unsigned            cand;

  // Round-robin search from ptr_q with wrap. A core whose ack is showing this
  // cycle may still hold req (it drops it next cycle), so it is masked out.
  always_comb begin
    elig    = core_req & ~core_ack_q;
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!found && elig[IDX_W'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_ack_d   = '0;
    core_rdata_d = core_rdata_q;
    proc_state_d = proc_state_q |
                   ((&core_done) && (state_q == IDLE) && (core_req == '0));

    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d       = win_idx;
          mem_en_d    = 1'b1;
          mem_we_d    = core_we[win_idx];
          mem_addr_d  = core_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = core_wdata[32'(win_idx)*WIDTH +: WIDTH];
          // Writes complete during ACCESS, so their ack is launched now.
          if (core_we[win_idx]) core_ack_d = NUM_CORES'(1) << win_idx;
          if (32'(win_idx) == NUM_CORES - 1) ptr_d = '0;
          else                               ptr_d = win_idx + IDX_W'(1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = mem_we_q ? IDLE : RESP;
      end
      RESP: begin
        core_rdata_d      = mem_rdata;
        core_ack_d[win_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ack_q   <= '0;
      core_rdata_q <= '0;
      proc_state_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      proc_state_q <= proc_state_d;
    end
  end

  assign core_ack   = core_ack_q;
  assign core_rdata = core_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign proc_state = proc_state_q;

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory between the NUM_CORES processor cores of the multi-core processor.
- Each core issues one read or write with a req/ack handshake. The arbiter serialises these onto the memory port, which has 1-cycle read latency.
- The arbiter also aggregates per-core halt flags into the processor-level proc_state completion flag that the top-level bench polls.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_WIDTH, 8, memory address width.
- WIDTH, 8, data word width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- core_req  in  NUM_CORES  per-core request; held until that core's ack.
- core_we  in  NUM_CORES  per-core write enable (1=write, 0=read).
- core_addr  in  NUM_CORES*ADDR_WIDTH  flattened addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  in  NUM_CORES*WIDTH  flattened write data.
- core_ack  out  NUM_CORES  one-hot, 1-cycle completion pulse.
- core_rdata  out  WIDTH  read data; valid when the ack of a read pulses.
- core_done  in  NUM_CORES  per-core halted flag.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid the cycle after mem_en with mem_we=0.
- proc_state  out  1  1 = all cores done and arbiter idle; sticky.

Behaviour:
- Reset (rstn=0 at an edge): state=IDLE, ptr=0, and the following are all 0: core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata, proc_state. Reset mid-transaction aborts it with no ack. Any pending core must re-request.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - If any core_req is set, pick the first requester searching upward from ptr with wrap (ptr, ptr+1, ... NUM_CORES-1, 0, ...).
  - Latch the winner index, we, addr and wdata into registers.
  - Drive mem_en=1, mem_we, mem_addr and mem_wdata from those registers next cycle. Go to ACCESS.
  - ptr <= winner+1, wrapping to 0 after NUM_CORES-1.
- ACCESS (exactly 1 cycle, mem_en=1):
  - Write: core_ack[winner]=1 this cycle; next state IDLE.
  - Read: next state RESP.
- RESP (1 cycle, mem_en=0): core_rdata<=mem_rdata registered and core_ack[winner]=1 in the same cycle; next state IDLE.
- Latency from the edge that samples req in IDLE: write ack 1 cycle later; read ack and data 2 cycles later.
- Throughput: a write takes 2 cycles and a read 3 cycles, counting the IDLE slot.
- mem_en, mem_we, mem_addr and mem_wdata are registered; mem_en=0 outside ACCESS. mem_addr and mem_wdata hold their last value when idle.
- core_rdata holds its last read value until the next read completes. It is never updated on writes.
- Core contract: req deasserted in the cycle after ack. The arbiter ignores req during ACCESS and RESP.
- The grant is stable for the whole transaction. A change on req, we, addr or wdata after sampling does not affect it.
- Fairness: with all cores requesting continuously, grants follow 0,1,2,3,0,... Every requester is served within NUM_CORES transactions.
- proc_state: set at the edge where &core_done==1, state==IDLE and core_req==0. It then stays 1 until reset. core_done dropping after that has no effect.
- Simultaneous events:
  - A new req arriving in the same cycle as another core's ack is arbitered in the next IDLE cycle.
  - A req coinciding with all-done in IDLE blocks proc_state until the access completes.

Test Plan:
- Reset mid-ACCESS (core 1 read of addr 0x20), release rstn -> no ack to core 1; all outputs 0; first grant afterwards searches from core 0.
- Core 2 writes 0x5A to 0x10, then reads 0x10 -> write ack 1 cycle after the sample edge with mem_we=1, mem_addr=0x10, mem_wdata=0x5A; read ack 2 cycles after its sample with core_rdata=0x5A.
- All 4 cores hold req continuously, each writing its own index to address index -> acks in order 0,1,2,3,0,1; never two acks in the same cycle; memory ends with [0..3]=0,1,2,3.
- ptr=3, cores 0 and 3 request together -> core 3 served first, then core 0.
- Core 0 changes addr from 0x01 to 0x02 during ACCESS -> mem_addr stays 0x01; the access completes unchanged.
- core_done=4'b1111 while core 1 has a read pending -> proc_state stays 0 until 1 cycle after the read's ack, then 1; later core_done=0 -> proc_state still 1.
